mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting cores/ports (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles waiting for read data before error completion.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m_req  input  NUM_MASTERS  per-master request; held high with stable command until that master's m_done.
REQ-006 m_we  input  NUM_MASTERS  per-master write (1) / read (0).
REQ-007 m_addr  input  NUM_MASTERS*32  per-master byte address, master i at bits [32i+31:32i].
REQ-008 m_wdata  input  NUM_MASTERS*32  per-master write data.
REQ-009 m_be  input  NUM_MASTERS*4  per-master byte enables.
REQ-010 m_done  output  NUM_MASTERS  one-cycle completion pulse to the served master.
REQ-011 m_err  output  1  valid with m_done; 1 = read timed out.
REQ-012 m_rdata  output  32  shared read data, valid with m_done for reads.
REQ-013 s_req, s_we, s_addr[32], s_wdata[32], s_be[4]  output  shared-memory command, all registered.
REQ-014 s_ready  input  1  memory accepts command when s_req && s_ready at a rising edge.
REQ-015 s_rvalid, s_rdata[32]  input  read response from memory.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; at most one outstanding transaction.
REQ-017 IDLE: if any m_req set, SHALL pick winner round-robin, searching from (last_grant+1) mod NUM_MASTERS upward with wrap; latch winner's we/addr/wdata/be into s_* regs, set last_grant=winner, go ISSUE; else stay IDLE.
REQ-018 ISSUE: s_req=1 with latched command; hold all s_* stable until s_req && s_ready; on acceptance write -> DONE, read -> WAIT with timeout counter cleared.
REQ-019 WAIT: s_req=0; on s_rvalid latch s_rdata into m_rdata, m_err=0, go DONE; counter increments each cycle without s_rvalid; when counter reaches TIMEOUT_CYCLES-1 without s_rvalid, m_rdata=32'h0, m_err=1, go DONE.
REQ-020 DONE: m_done[winner]=1 for exactly one cycle, all other bits 0; next state IDLE; m_req is not sampled for arbitration in DONE (prevents re-grant on stale request).
REQ-021 Latency, s_ready=1 throughout: write m_done 2 cycles after the IDLE sampling edge; read with s_rvalid one cycle after acceptance, m_done 3 cycles after.
REQ-022 s_rvalid outside WAIT SHALL be ignored; requests arriving outside IDLE SHALL wait (not dropped).
REQ-023 m_err and m_rdata SHALL hold their values until the next DONE; for writes m_err=0 and m_rdata unchanged.
REQ-024 Simultaneous requests from all masters SHALL be served in strict rotation; no master waits more than NUM_MASTERS-1 other grants.
REQ-025 A single continuously requesting master SHALL be re-granted on every IDLE visit.

Reset
REQ-026 On rst_n low: state=IDLE, last_grant=NUM_MASTERS-1 (master 0 wins first), s_req=0, s_we=0, s_addr/s_wdata=0, s_be=0, m_done=0, m_err=0, m_rdata=0, counter=0.
REQ-027 Reset mid-transaction SHALL abandon it with no m_done pulse; first post-reset grant follows REQ-026.

Verification
REQ-028 Reset, then m_req=2'b11 both reads, s_ready=1, s_rvalid 1 cycle after accept -> master 0 served first, master 1 second; m_done pulses 01 then 10, never both.
REQ-029 Master 1 write addr 0x100, wdata 0xA5A5A5A5, be 4'hF, s_ready low 3 cycles -> s_* stable during stall, one accept, m_done[1] next cycle, m_err=0.
REQ-030 Master 0 read, s_rvalid never asserted, TIMEOUT_CYCLES=16 -> m_done[0] with m_err=1, m_rdata=0, 16 cycles after acceptance.
REQ-031 Both masters request continuously for 10 transactions -> grants alternate 0,1,0,1...; spurious s_rvalid in IDLE changes nothing.
REQ-032 rst_n low while in WAIT -> no m_done, all outputs per REQ-026; next request from master 1 alone is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_MASTERS cores one-at-a-time access to a shared memory port.
// Latency: write done 2 cycles / read done 3+ cycles after grant; s_* held stable while !s_ready, losers hold m_req.
module mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]  m_be,
    output logic [NUM_MASTERS-1:0]    m_done,
    output logic                      m_err,
    output logic [31:0]               m_rdata,
    output logic                      s_req,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_be,
    input  logic                      s_ready,
    input  logic                      s_rvalid,
    input  logic [31:0]               s_rdata
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    state_t        state;
    cmd_t          cmd_q;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          any_req;
    logic [CW-1:0] cnt;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        return IW'((int'(base) + k) % NUM_MASTERS);
    endfunction

    // Walk candidates from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner  = '0;
        any_req = |m_req;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (m_req[rr_idx(last_grant, k)]) begin
                winner = rr_idx(last_grant, k);
            end
        end
    end

    assign s_we    = cmd_q.we;
    assign s_addr  = cmd_q.addr;
    assign s_wdata = cmd_q.wdata;
    assign s_be    = cmd_q.be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_MASTERS - 1);
            cmd_q      <= '0;
            s_req      <= 1'b0;
            m_done     <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
            cnt        <= '0;
        end else begin
            m_done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cmd_q.we    <= m_we[winner];
                        cmd_q.addr  <= m_addr[32*int'(winner) +: 32];
                        cmd_q.wdata <= m_wdata[32*int'(winner) +: 32];
                        cmd_q.be    <= m_be[4*int'(winner) +: 4];
                        last_grant  <= winner;
                        s_req       <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (s_ready) begin
                        s_req <= 1'b0;
                        cnt   <= '0;
                        if (cmd_q.we) begin
                            m_err              <= 1'b0;
                            m_done[last_grant] <= 1'b1;
                            state              <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (s_rvalid) begin
                        m_rdata            <= s_rdata;
                        m_err              <= 1'b0;
                        m_done[last_grant] <= 1'b1;
                        state              <= DONE;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        m_rdata            <= '0;
                        m_err              <= 1'b1;
                        m_done[last_grant] <= 1'b1;
                        state              <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // m_done is high during this state; requests are ignored so a stale m_req cannot re-grant.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
